// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  // States in which the loader accepts stream bytes.
  function automatic logic takes_bytes(input state_t s);
    return (s == HDR_HI) || (s == HDR_LO) || (s == DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words (first byte lands in [31:24]).
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word;

  // Byte counter wraps 3->0 so each word starts fresh without an explicit clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_word     <= 32'd0;
    end else if (i_clear) begin
      r_byte_cnt <= 2'd0;
      r_word     <= 32'd0;
    end else if (i_shift_en) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_word     <= o_word_next;
    end
  end

  assign o_word_next = {r_word[23:0], i_byte};
  // High while the next shifted byte completes the word.
  assign o_word_full = (r_byte_cnt == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Loads a counted byte-stream image into instruction memory and holds the core in reset until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  state_t      r_state, w_next_state;
  logic [15:0] r_count, r_word_cnt, w_hdr_count;
  logic        r_in_ready, r_mem_we, r_cpu_rst, r_busy, r_done, r_error;
  logic [31:0] r_mem_wdata;
  logic        w_xfer, w_start_ok, w_shift, w_word_full;
  logic [31:0] w_word_next;

  assign w_xfer      = i_in_valid & r_in_ready;
  assign w_start_ok  = i_start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign w_hdr_count = {r_count[15:8], i_in_data};

  imem_loader_word_assembler u_word_assembler (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_shift_en  (w_shift),
    .i_byte      (i_in_data),
    .o_word_next (w_word_next),
    .o_word_full (w_word_full)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and byte-shift enable.
  always_comb begin
    w_next_state = r_state;
    w_shift      = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_start_ok) w_next_state = HDR_HI;
        else            w_next_state = r_state;
      end
      HDR_HI: begin
        if (w_xfer) w_next_state = HDR_LO;
        else        w_next_state = HDR_HI;
      end
      HDR_LO: begin
        if (!w_xfer)                                               w_next_state = HDR_LO;
        else if ((w_hdr_count == 16'd0) || (w_hdr_count > 16'(DEPTH))) w_next_state = ERR;
        else                                                       w_next_state = DATA;
      end
      DATA: begin
        if (w_xfer) begin
          w_shift = 1'b1;
          if (w_word_full) w_next_state = WRITE;
          else             w_next_state = DATA;
        end else begin
          w_next_state = DATA;
        end
      end
      WRITE: begin
        if ((r_word_cnt + 16'd1) == r_count) w_next_state = DONE;
        else                                 w_next_state = DATA;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Header capture, word counter and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 16'd0;
      r_word_cnt  <= 16'd0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 32'd0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (w_start_ok)             r_word_cnt <= 16'd0;
      else if (r_state == WRITE)  r_word_cnt <= r_word_cnt + 16'd1;
      if ((r_state == HDR_HI) && w_xfer) r_count[15:8] <= i_in_data;
      if ((r_state == HDR_LO) && w_xfer) r_count[7:0]  <= i_in_data;
      if (w_next_state == WRITE)  r_mem_wdata <= w_word_next;
      r_in_ready <= takes_bytes(w_next_state);
      r_busy     <= takes_bytes(w_next_state) | (w_next_state == WRITE);
      r_mem_we   <= (w_next_state == WRITE);
      r_cpu_rst  <= (w_next_state != DONE);
      r_done     <= (w_next_state == DONE);
      r_error    <= (w_next_state == ERR);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_word_cnt[ADDR_W-1:0];
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_rst   = r_cpu_rst;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule
